// File: rtl/fft_modulus_reader.sv
// Reads one FFT modulus frame from a sync FIFO, streams it out with bin indices,
// and reports the largest word of the frame together with its index.
module fft_modulus_reader #(
  parameter int DATA_WIDTH = 73,
  parameter int FRAME_LEN  = 1024,
  parameter int IDX_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [IDX_WIDTH-1:0]  m_index,
  output logic                  m_last,
  output logic                  peak_valid,
  output logic [DATA_WIDTH-1:0] peak_value,
  output logic [IDX_WIDTH-1:0]  peak_index
);

  localparam int CNT_WIDTH = IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] READS_TOTAL = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] READS_LAST  = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] INDEX_LAST  = IDX_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic [IDX_WIDTH-1:0]  out_index;
  logic                  in_flight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [DATA_WIDTH-1:0] run_peak;
  logic [IDX_WIDTH-1:0]  run_index;

  logic                  accept;
  logic                  reads_left;
  logic [2:0]            occupancy;
  logic                  take_peak;
  logic [DATA_WIDTH-1:0] next_peak;
  logic [IDX_WIDTH-1:0]  next_peak_index;

  assign m_valid = (buf_count != 2'd0);
  assign accept  = m_valid && m_ready;
  assign m_data  = buf_head;
  assign m_index = out_index;
  assign m_last  = m_valid && (out_index == INDEX_LAST);

  // The beat leaving this cycle frees its slot, which is what lets the
  // pipeline sustain one word per cycle without ever holding more than two.
  assign occupancy  = {2'b00, in_flight} + {1'b0, buf_count} - {2'b00, accept};
  assign reads_left = (rd_count < READS_TOTAL);
  assign fifo_rd_en = (state == READ) && !fifo_rd_empty && reads_left
                      && (occupancy < 3'd2);

  assign take_peak       = accept && ((out_index == '0) || (buf_head > run_peak));
  assign next_peak       = take_peak ? buf_head  : run_peak;
  assign next_peak_index = take_peak ? out_index : run_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rd_count   <= '0;
      out_index  <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_index <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (fifo_rd_en) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      if (accept) begin
        out_index <= out_index + IDX_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            busy      <= 1'b1;
            rd_count  <= '0;
            out_index <= '0;
          end
        end
        READ: begin
          if (fifo_rd_en && (rd_count == READS_LAST)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept && m_last) begin
            state      <= DONE;
            peak_valid <= 1'b1;
            peak_value <= next_peak;
            peak_index <= next_peak_index;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer: head drives the stream, tail absorbs the word
  // that was already in flight when the consumer stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= 1'b0;
      buf_count <= 2'd0;
      buf_head  <= '0;
      buf_tail  <= '0;
      run_peak  <= '0;
      run_index <= '0;
    end else begin
      in_flight <= fifo_rd_en;
      if (take_peak) begin
        run_peak  <= buf_head;
        run_index <= out_index;
      end
      case ({accept, in_flight})
        2'b01: begin
          if (buf_count == 2'd0) begin
            buf_head <= fifo_rd_data;
          end else begin
            buf_tail <= fifo_rd_data;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b10: begin
          if (buf_count == 2'd2) begin
            buf_head <= buf_tail;
          end
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_head <= fifo_rd_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_modulus_reader.sv
// Directed bench for fft_modulus_reader with an 8-word frame, a behavioural
// 1-cycle-latency FIFO and a stream monitor sampling on the falling edge.
module tb_fft_modulus_reader;

  localparam int DW = 20;
  localparam int FL = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b1;
  logic          busy, fifo_rd_en, fifo_rd_empty, m_valid, m_last, peak_valid;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] m_data, peak_value;
  logic [IW-1:0] m_index, peak_index;

  always #5 clk = ~clk;

  fft_modulus_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .peak_valid(peak_valid), .peak_value(peak_value),
    .peak_index(peak_index)
  );

  // Behavioural sync FIFO: data appears one clock after the read edge.
  logic [DW-1:0] fifo_mem [0:127];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  bit            flush_req = 1'b0;
  assign fifo_rd_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr[6:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_beats = 0, issued = 0, accepted = 0;
  int            pv_count = 0, pv_cyc = 0, start_cyc = 0;
  int            rd_empty_viol = 0, out_viol = 0, hold_viol = 0;
  bit            pv_busy = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [IW-1:0] prev_index = '0;
  logic [DW-1:0] beat_data  [0:255];
  logic [IW-1:0] beat_index [0:255];
  logic          beat_last  [0:255];
  int            beat_cyc   [0:255];

  // Falling-edge monitor: inputs and outputs are stable here, so a beat seen
  // with valid&ready is the one the next rising edge accepts.
  always @(negedge clk) begin
    if (rst) begin
      accepted   = issued;
      prev_stall = 1'b0;
    end else begin
      if (start) start_cyc = cyc;
      if (fifo_rd_en && fifo_rd_empty) rd_empty_viol++;
      if (issued - accepted > 2) out_viol++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_index !== prev_index))
        hold_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_index = m_index;
      if (peak_valid) begin
        pv_count++;
        pv_cyc  = cyc;
        pv_busy = busy;
      end
      if (m_valid && m_ready) begin
        beat_data[n_beats[7:0]]  = m_data;
        beat_index[n_beats[7:0]] = m_index;
        beat_last[n_beats[7:0]]  = m_last;
        beat_cyc[n_beats[7:0]]   = cyc;
        n_beats++;
        accepted++;
      end
      if (fifo_rd_en && !fifo_rd_empty) issued++;
    end
  end

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] late_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [DW-1:0] w, input bit late);
    if (late) begin
      late_q.push_back(w);
    end else begin
      fifo_mem[wr_ptr[6:0]] = w;
      wr_ptr++;
    end
    exp_q.push_back(w);
  endtask

  task automatic releaseLate();
    foreach (late_q[i]) begin
      fifo_mem[wr_ptr[6:0]] = late_q[i];
      wr_ptr++;
    end
    late_q.delete();
  endtask

  task automatic flushFifo();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkFrame(input string tag, input int base);
    checkOutput({tag, "_beats"}, n_beats - base, FL);
    for (int i = 0; i < FL; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), beat_data[base + i], exp_q[i]);
      checkOutput($sformatf("%s_index%0d", tag, i), beat_index[base + i], i);
      checkOutput($sformatf("%s_last%0d", tag, i), beat_last[base + i], (i == FL - 1));
    end
    exp_q.delete();
  endtask

  // Pulses start, then runs until busy drops; optional ready toggling,
  // late FIFO refill and a second start pulse while busy.
  task automatic applyStimulus(input bit toggle, input int refill_at, input int restart_at,
                               output bit completed);
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    completed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == refill_at) releaseLate();
      start = (i == restart_at);
      if (toggle) m_ready = ~m_ready;
      tick();
      if (!busy) begin
        completed = 1'b1;
        break;
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit done;
    int base, pv_before;

    // Reset state, with words already waiting in the FIFO
    pushWord(20'h00010, 0); pushWord(20'h80001, 0); pushWord(20'h00020, 0); pushWord(20'h7FFFF, 0);
    pushWord(20'h80001, 0); pushWord(20'h00003, 0); pushWord(20'h00004, 0); pushWord(20'h00005, 0);
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", fifo_rd_en, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_peak_valid", peak_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_index", m_index, 0);
    checkOutput("rst_peak_value", peak_value, 0);
    checkOutput("rst_peak_index", peak_index, 0);
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("idle_rd_en", fifo_rd_en, 0);
    checkOutput("idle_busy", busy, 0);

    // Scenario 1: full-rate frame, unsigned compare, earliest tie wins
    $display("[TB] scenario 1: back-to-back frame");
    base = n_beats;
    pv_before = pv_count;
    applyStimulus(0, -1, -1, done);
    checkOutput("s1_done", done, 1);
    checkFrame("s1", base);
    checkOutput("s1_first_latency", beat_cyc[base] - start_cyc, 3);
    checkOutput("s1_consecutive", beat_cyc[base + 7] - beat_cyc[base], 7);
    checkOutput("s1_pv_after_last", pv_cyc - beat_cyc[base + 7], 1);
    checkOutput("s1_pv_busy", pv_busy, 1);
    checkOutput("s1_pv_count", pv_count - pv_before, 1);
    checkOutput("s1_peak_value", peak_value, 20'h80001);
    checkOutput("s1_peak_index", peak_index, 1);

    // Scenario 2: ready toggles every cycle
    $display("[TB] scenario 2: toggling ready");
    for (int i = 0; i < FL; i++) pushWord(DW'(8'h11 * (i + 1)), 0);
    base = n_beats;
    applyStimulus(1, -1, -1, done);
    checkOutput("s2_done", done, 1);
    checkFrame("s2", base);
    checkOutput("s2_hold_viol", hold_viol, 0);
    checkOutput("s2_outstanding_viol", out_viol, 0);
    checkOutput("s2_peak_value", peak_value, 20'h00088);
    checkOutput("s2_peak_index", peak_index, 7);

    // Scenario 3: FIFO runs dry after 3 words, refilled later
    $display("[TB] scenario 3: FIFO underrun");
    pushWord(20'h000A0, 0); pushWord(20'h000A1, 0); pushWord(20'h000A2, 0);
    pushWord(20'h00003, 1); pushWord(20'h00004, 1); pushWord(20'h00005, 1);
    pushWord(20'h00006, 1); pushWord(20'h00007, 1);
    base = n_beats;
    applyStimulus(0, 10, -1, done);
    checkOutput("s3_done", done, 1);
    checkFrame("s3", base);
    checkOutput("s3_rd_en_while_empty", rd_empty_viol, 0);
    checkOutput("s3_peak_value", peak_value, 20'h000A2);
    checkOutput("s3_peak_index", peak_index, 2);

    // Scenario 4: data 5,9,2,9,1,0,3,4
    $display("[TB] scenario 4: peak tie");
    pushWord(20'd5, 0); pushWord(20'd9, 0); pushWord(20'd2, 0); pushWord(20'd9, 0);
    pushWord(20'd1, 0); pushWord(20'd0, 0); pushWord(20'd3, 0); pushWord(20'd4, 0);
    base = n_beats;
    applyStimulus(0, -1, -1, done);
    checkOutput("s4_done", done, 1);
    checkFrame("s4", base);
    checkOutput("s4_peak_value", peak_value, 20'd9);
    checkOutput("s4_peak_index", peak_index, 1);
    repeat (5) tick();
    checkOutput("s4_peak_value_held", peak_value, 20'd9);
    checkOutput("s4_peak_index_held", peak_index, 1);

    // Scenario 5: start while busy, surplus FIFO words
    $display("[TB] scenario 5: restart ignored, surplus words");
    for (int i = 0; i < 12; i++) pushWord(DW'(12'h100 + i), 0);
    base = n_beats;
    pv_before = pv_count;
    applyStimulus(0, -1, 3, done);
    checkOutput("s5_done", done, 1);
    checkFrame("s5", base);
    repeat (6) tick();
    checkOutput("s5_no_second_frame", busy, 0);
    checkOutput("s5_words_left", wr_ptr - rd_ptr, 4);
    checkOutput("s5_beats_total", n_beats - base, FL);
    checkOutput("s5_pv_count", pv_count - pv_before, 1);
    checkOutput("s5_peak_value", peak_value, 20'h00107);
    checkOutput("s5_peak_index", peak_index, 7);
    flushFifo();

    // Scenario 6: reset after the third beat, then a fresh frame
    $display("[TB] scenario 6: reset mid-frame");
    for (int i = 0; i < FL; i++) pushWord(DW'(8'hC0 + i), 0);
    exp_q.delete();
    base = n_beats;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (n_beats - base >= 3) break;
    end
    checkOutput("s6_beats_before_reset", n_beats - base, 3);
    pv_before = pv_count;
    rst = 1'b1;
    #1;
    checkOutput("s6_busy", busy, 0);
    checkOutput("s6_rd_en", fifo_rd_en, 0);
    checkOutput("s6_m_valid", m_valid, 0);
    checkOutput("s6_m_last", m_last, 0);
    checkOutput("s6_peak_valid", peak_valid, 0);
    checkOutput("s6_m_data", m_data, 0);
    checkOutput("s6_m_index", m_index, 0);
    checkOutput("s6_peak_value", peak_value, 0);
    checkOutput("s6_peak_index", peak_index, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("s6_no_peak_pulse", pv_count - pv_before, 0);
    flushFifo();
    pushWord(20'h0003F, 0);
    for (int i = 1; i < FL; i++) pushWord(DW'(8'h30 + i), 0);
    base = n_beats;
    applyStimulus(0, -1, -1, done);
    checkOutput("s6_done", done, 1);
    checkFrame("s6", base);
    checkOutput("s6_peak_value_new", peak_value, 20'h0003F);
    checkOutput("s6_peak_index_new", peak_index, 0);

    checkOutput("all_rd_en_while_empty", rd_empty_viol, 0);
    checkOutput("all_outstanding_viol", out_viol, 0);
    checkOutput("all_hold_viol", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
